// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and default pattern shared by the 10101 transmitter and detectors
package seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_e;
    localparam logic [4:0] DEFAULT_PATTERN = 5'b10101;
endpackage

// File: rtl/seq_tx_10101_piso_shreg.sv
// piso_shreg: parallel-load, MSB-first shift register exposing only the bit that goes out next
module piso_shreg #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         msb_o
);
    logic [W-1:0] q_q;
    // load wins over shift; zeros fill from the LSB side
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_q <= '0;
        else if (load_i) q_q <= d_i;
        else if (shift_i) q_q <= {q_q[W-2:0], 1'b0};
    end
    assign msb_o = q_q[W-1];
endmodule

// File: rtl/seq_tx_10101.sv
// seq_tx_10101: MSB-first serial pattern transmitter with repeat count and idle gap; define SEQ_TX_PARITY_EN to append an even-parity bit to every repetition
module seq_tx_10101
    import seq_pkg::*;
#(
    parameter int PATTERN_W = 5,
    parameter int REPEAT_W  = 4,
    parameter int GAP       = 1
) (
    input  logic                 fsm_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [REPEAT_W-1:0]  repeat_cnt,
    input  logic                 abort,
    output logic                 ready,
    output logic                 dout,
    output logic                 dout_valid,
    output logic                 done,
    output logic [1:0]           ps
);
    localparam int BW     = $clog2(PATTERN_W);
    localparam int GW     = GAP > 1 ? $clog2(GAP) : 1;
    localparam int GAP_LD = GAP > 0 ? GAP - 1 : 0;

    state_e               ps_q, ps_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [REPEAT_W-1:0]  rep_q, rep_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [PATTERN_W-1:0] pat_q, pat_d, ld_val;
    logic ready_q, dout_q, dv_q, done_q;
    logic ready_d, dout_d, dv_d, done_d;
    logic accept, last_bit, to_par, par_bit, reload, load, shift, sr_msb;

    // The shift register holds the bits still to send after the one on dout,
    // so its MSB is always the next data bit and dout can stay registered.
    piso_shreg #(.W(PATTERN_W)) u_shreg (
        .clk_i   (fsm_clk),
        .rst_ni  (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .d_i     ({ld_val[PATTERN_W-2:0], 1'b0}),
        .msb_o   (sr_msb)
    );

`ifdef SEQ_TX_PARITY_EN
    assign to_par   = ps_q == ST_SHIFT && bit_q == '0;
    assign last_bit = ps_q == ST_PARITY;
    assign par_bit  = ^pat_q;
`else
    assign to_par   = 1'b0;
    assign last_bit = ps_q == ST_SHIFT && bit_q == '0;
    assign par_bit  = 1'b0;
`endif

    assign accept = ps_q == ST_IDLE && start && !abort;
    assign reload = (ps_q == ST_GAP && gap_q == '0) || (last_bit && rep_q != '0 && GAP == 0);
    assign load   = accept || reload;
    assign shift  = ps_q == ST_SHIFT && bit_q != '0;
    assign ld_val = accept ? pattern_in : pat_q;

    // state and output registers
    always_ff @(posedge fsm_clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q    <= ST_IDLE;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
            ready_q <= 1'b1;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            pat_q   <= pat_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
        end
    end

    // next state and counters; abort beats start, reload beats end-of-repetition
    always_comb begin
        ps_d  = ps_q;
        bit_d = bit_q;
        rep_d = rep_q;
        gap_d = gap_q;
        pat_d = pat_q;
        if (abort && ps_q != ST_IDLE) begin
            ps_d = ST_IDLE;
        end else if (accept) begin
            ps_d  = ST_SHIFT;
            bit_d = BW'(PATTERN_W - 1);
            rep_d = repeat_cnt;
            pat_d = pattern_in;
        end else if (reload) begin
            ps_d  = ST_SHIFT;
            bit_d = BW'(PATTERN_W - 1);
            rep_d = rep_q - REPEAT_W'(1);
        end else if (to_par) begin
            ps_d = ST_PARITY;
        end else if (last_bit) begin
            ps_d  = rep_q == '0 ? ST_IDLE : ST_GAP;
            gap_d = GW'(GAP_LD);
        end else if (ps_q == ST_GAP) begin
            gap_d = gap_q - GW'(1);
        end else if (shift) begin
            bit_d = bit_q - BW'(1);
        end
    end

    // registered outputs follow the state being entered
    always_comb begin
        ready_d = ps_d == ST_IDLE;
        dv_d    = ps_d == ST_SHIFT || ps_d == ST_PARITY;
        done_d  = ps_d == ST_IDLE && ps_q != ST_IDLE && !abort;
        dout_d  = ps_d == ST_PARITY ? par_bit :
                  ps_d == ST_SHIFT  ? (load ? ld_val[PATTERN_W-1] : sr_msb) : 1'b0;
    end

    assign ready      = ready_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign done       = done_q;
    assign ps         = ps_q;
endmodule
